// File: rtl/spi_slave.sv
// SPI slave, modes 0-3, LSB first, with all SPI pins resynchronized into clk.
// Define SPI_SLAVE_OVERRUN_EN for a held rx_valid with rx_ack and a sticky overrun flag.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic              rx_ack,
    output logic              overrun,
`endif
    output logic              busy
);
    localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_prev_q, armed_q, cpol_q, cpha_q;
    logic [CNT_W-1:0]       bit_cnt_q, tx_idx_q;
    logic [DATA_W-1:0]      rx_shift_q, tx_buf_q, rx_data_q;
    logic                   miso_q, rx_valid_q, busy_q, tx_ready_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                   overrun_q;
`endif

    logic              sclk_s, cs_s, mosi_s;
    logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic              sample_d, shift_d, load_d;
    logic [DATA_W-1:0] tx_word_d, rx_word_d;
    logic [CNT_W-1:0]  tx_idx_inc_d;

    assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s         = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise    = sclk_s & ~sclk_prev_q;
    assign sclk_fall    = ~sclk_s & sclk_prev_q;
    assign lead_edge    = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge   = cpol_q ? sclk_rise : sclk_fall;
    assign sample_d     = cpha_q ? trail_edge : lead_edge;
    assign shift_d      = cpha_q ? lead_edge : trail_edge;
    assign load_d       = tx_load & tx_ready_q;
    assign tx_word_d    = load_d ? tx_data : tx_buf_q;
    assign rx_word_d    = {mosi_s, rx_shift_q[DATA_W-1:1]};
    assign tx_idx_inc_d = (tx_idx_q == LAST) ? '0 : tx_idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tx_idx_q    <= '0;
            rx_shift_q  <= '0;
            tx_buf_q    <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun_q   <= 1'b0;
`endif
        end else begin
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                mosi_sync_q[i] <= mosi_sync_q[i-1];
                fill_q[i]      <= fill_q[i-1];
            end
            sclk_sync_q[0] <= sclk;
            cs_sync_q[0]   <= cs_n;
            mosi_sync_q[0] <= mosi;
            fill_q[0]      <= 1'b1;
            sclk_prev_q    <= sclk_s;

            // cs_n only counts as high once the reset value has drained out of the synchronizer
            if (fill_q[SYNC_STAGES-1] && cs_s)
                armed_q <= 1'b1;

`ifdef SPI_SLAVE_OVERRUN_EN
            if (rx_ack) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
`else
            rx_valid_q <= 1'b0;
`endif

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (load_d)
                        tx_buf_q <= tx_data;
                    if (armed_q && !cs_s) begin
                        state_q    <= ACTIVE;
                        armed_q    <= 1'b0;
                        cpol_q     <= mode[1];
                        cpha_q     <= mode[0];
                        bit_cnt_q  <= '0;
                        tx_idx_q   <= '0;
                        busy_q     <= 1'b1;
                        tx_ready_q <= 1'b0;
                        miso_q     <= mode[0] ? 1'b0 : tx_word_d[0];
                    end
                end
                ACTIVE: begin
                    if (cs_s) begin
                        state_q    <= IDLE;
                        bit_cnt_q  <= '0;
                        tx_idx_q   <= '0;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                        miso_q     <= 1'b0;
                    end else begin
                        if (sample_d) begin
                            rx_shift_q <= rx_word_d;
                            if (bit_cnt_q == LAST) begin
                                bit_cnt_q  <= '0;
                                rx_data_q  <= rx_word_d;
                                rx_valid_q <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
                                if (rx_valid_q)
                                    overrun_q <= 1'b1;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        // CPHA=1 presents the current bit; CPHA=0 already shows bit 0 and moves on
                        if (shift_d) begin
                            tx_idx_q <= tx_idx_inc_d;
                            miso_q   <= cpha_q ? tx_buf_q[tx_idx_q] : tx_buf_q[tx_idx_inc_d];
                        end
                    end
                end
            endcase
        end
    end

    assign miso     = miso_q;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
`ifdef SPI_SLAVE_OVERRUN_EN
    assign overrun  = overrun_q;
`endif

endmodule
